sram_cmd_queue: RTL
===================

SRAM_CMD_QUEUE -- requirements
Module: sram_cmd_queue

Interface
REQ-001: Parameter DEPTH, default 4, sets command FIFO entries; legal values are powers of two from 2 to 16.
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: cmd_valid  input  1  client command present.
REQ-005: cmd_ready  output  1  queue can accept a command; equals "FIFO not full".
REQ-006: cmd_write  input  1  1 = write, 0 = read.
REQ-007: cmd_addr  input  15  word address.
REQ-008: cmd_wdata  input  16  write data; ignored for reads.
REQ-009: rsp_valid  output  1  one-cycle pulse; rsp_data holds the read result.
REQ-010: rsp_data  output  16  read data; holds its last value between pulses.
REQ-011: ctrl_read_req  output  1  read request pulse to the SRAM controller.
REQ-012: ctrl_write_req  output  1  write request pulse to the SRAM controller.
REQ-013: ctrl_address  output  15  address to the controller; stable from the request cycle until completion.
REQ-014: ctrl_write_data  output  16  write data to the controller; stable from the request cycle until completion.
REQ-015: ctrl_read_data  input  16  controller read data; valid in the completion cycle.
REQ-016: ctrl_ready  input  1  controller idle (1) or busy (0).
REQ-017: fifo_count  output  $clog2(DEPTH)+1  number of queued commands, excluding the one in flight.
REQ-018: busy  output  1  FSM is not in IDLE, or fifo_count is nonzero.

Function
REQ-019: A command is pushed on a rising edge where cmd_valid and cmd_ready are both 1; FIFO order is strict first in, first out.
REQ-020: FSM states and transitions are:
  - IDLE: go to ISSUE when the FIFO is non-empty and ctrl_ready = 1.
  - ISSUE: go to WAIT_ACK unconditionally.
  - WAIT_ACK: go to WAIT_DONE when ctrl_ready = 0.
  - WAIT_DONE: go to IDLE when ctrl_ready = 1.
REQ-021: On the IDLE->ISSUE edge, the head entry is popped and latched into ctrl_address, ctrl_write_data and an internal op bit.
REQ-022: ctrl_write_req (write) or ctrl_read_req (read) is 1 for exactly the single cycle spent in ISSUE; both are never 1 together.
REQ-023: Completion is the WAIT_DONE cycle with ctrl_ready = 1.
REQ-024: At completion of a read, ctrl_read_data is captured into rsp_data, and rsp_valid pulses in the next cycle.
REQ-025: Writes produce no response pulse.
REQ-026: Latency: a command pushed into an empty queue at edge N, with ctrl_ready held 1, has its request asserted during cycle N+1 to N+2.
REQ-027: A push and a pop on the same edge both take effect, and fifo_count is unchanged.
REQ-028: When the FIFO is full, cmd_ready = 0 and cmd_valid is ignored; a pop on that edge makes cmd_ready = 1 in the next cycle.
REQ-029: FIFO pointers wrap modulo DEPTH with no loss of entries.
REQ-030: Only one command is in flight at a time; no new request is issued until the FSM returns to IDLE.
REQ-031: If ctrl_ready is 0 while in IDLE, the FSM stays in IDLE and the queue keeps accepting commands until full.

Reset
REQ-032: When rst_n = 0, the following are cleared immediately (asynchronously):
  - FSM returns to IDLE.
  - FIFO is emptied (pointers and fifo_count = 0).
  - ctrl_read_req, ctrl_write_req and rsp_valid = 0.
  - ctrl_address, ctrl_write_data and rsp_data = 0.
  - busy = 0 and cmd_ready = 1.
REQ-033: Reset asserted mid-transaction abandons the in-flight command and all queued commands, and no rsp_valid pulse follows.
REQ-034: The first push is possible on the first rising edge after rst_n deasserts.

Verification
REQ-035: Write then read: push write 0x1234 <- 0xABCD, then read 0x1234, using a controller model with a 3-cycle busy time -> one ctrl_write_req pulse and one ctrl_read_req pulse; then rsp_valid pulses once with rsp_data = 0xABCD.
REQ-036: Fill with ctrl_ready = 0: push DEPTH+1 commands -> cmd_ready drops after DEPTH pushes and fifo_count = DEPTH; releasing ctrl_ready drains the commands in order.
REQ-037: Back-to-back reads: read addresses 0x0000, 0x7FFF and 0x0001, preloaded with 0x1111, 0x2222 and 0x3333 -> three rsp_valid pulses carrying those values in that order.
REQ-038: Wrap-around: push and drain 3*DEPTH alternating writes and reads to distinct addresses -> every read returns its matching written data and fifo_count ends at 0.
REQ-039: Reset in WAIT_DONE of a read: assert rst_n = 0 -> no rsp_valid pulse, fifo_count = 0, both request outputs low, busy = 0.
REQ-040: Simultaneous push and pop with 2 entries queued -> fifo_count stays 2 across that edge.

Source files
------------

// File: rtl/sram_cmd_queue.sv
// Command FIFO in front of a single-outstanding SRAM controller handshake.
// Commands are queued FIFO-order and issued one at a time; reads return data on rsp_*.
//
// state     | meaning
// IDLE      | nothing in flight; pop head when FIFO non-empty and controller idle
// ISSUE     | one-cycle request pulse to the controller
// WAIT_ACK  | waiting for controller to go busy
// WAIT_DONE | waiting for controller to return idle (completion)
module sram_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [14:0]              cmd_addr,
    input  logic [15:0]              cmd_wdata,
    output logic                     rsp_valid,
    output logic [15:0]              rsp_data,
    output logic                     ctrl_read_req,
    output logic                     ctrl_write_req,
    output logic [14:0]              ctrl_address,
    output logic [15:0]              ctrl_write_data,
    input  logic [15:0]              ctrl_read_data,
    input  logic                     ctrl_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    logic [14:0]   addr_mem  [DEPTH];
    logic [15:0]   wdata_mem [DEPTH];
    logic          op_mem    [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_t        state_q;
    logic          rd_req_q;
    logic          wr_req_q;
    logic          op_write_q;
    logic [14:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   rsp_data_q;
    logic          rsp_valid_q;

    logic          push;
    logic          pop;

    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0) && ctrl_ready;

    // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q]  <= cmd_addr;
            wdata_mem[wr_ptr_q] <= cmd_wdata;
            op_mem[wr_ptr_q]    <= cmd_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q    <= ISSUE;
                        addr_q     <= addr_mem[rd_ptr_q];
                        wdata_q    <= wdata_mem[rd_ptr_q];
                        op_write_q <= op_mem[rd_ptr_q];
                        wr_req_q   <= op_mem[rd_ptr_q];
                        rd_req_q   <= !op_mem[rd_ptr_q];
                    end
                end
                ISSUE: begin
                    state_q  <= WAIT_ACK;
                    wr_req_q <= 1'b0;
                    rd_req_q <= 1'b0;
                end
                WAIT_ACK: begin
                    if (!ctrl_ready) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (ctrl_ready) begin
                        state_q <= IDLE;
                        if (!op_write_q) begin
                            rsp_data_q  <= ctrl_read_data;
                            rsp_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_req_q <= 1'b0;
                    rd_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_read_req   = rd_req_q;
    assign ctrl_write_req  = wr_req_q;
    assign ctrl_address    = addr_q;
    assign ctrl_write_data = wdata_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_valid       = rsp_valid_q;
    assign fifo_count      = count_q;
    assign busy            = (state_q != IDLE) || (count_q != '0);

endmodule
